// File: rtl/cv32e40p_x_result_buf.sv
// In-order buffer for coprocessor results, draining into register-file port B when the core leaves it free.
// Optional zero-latency path when the buffer is empty: define CV32E40P_X_RESULT_BYPASS_EN.
module cv32e40p_x_result_buf #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        x_result_valid_i,
    output logic        x_result_ready_o,
    input  logic [3:0]  x_result_id_i,
    input  logic [31:0] x_result_data_i,
    input  logic [4:0]  x_result_rd_i,
    input  logic        x_result_we_i,
    input  logic        core_we_wb_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        sb_clear_valid_o,
    output logic [4:0]  sb_clear_rd_o,
    output logic [3:0]  sb_clear_id_o,
    output logic        x_wb_stall_req_o,
    output logic        buf_empty_o,
    output logic        buf_full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

    // Wrap explicitly so non-power-of-two depths index correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    logic [31:0]      data_mem_r [DEPTH];
    logic [4:0]       rd_mem_r   [DEPTH];
    logic [3:0]       id_mem_r   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [3:0]       starve_r;

    logic empty_s;
    logic full_s;
    logic accept_s;
    logic push_s;
    logic pop_s;
    logic bypass_s;

    // Status is forced to its idle value while reset is held so outputs never reflect stale state.
    assign empty_s  = (count_r == {CNT_W{1'b0}}) | ~rst_ni;
    assign full_s   = (count_r == DEPTH_CNT) & rst_ni;
    assign accept_s = x_result_valid_i & ~full_s & rst_ni;
    assign pop_s    = ~empty_s & ~core_we_wb_i;

`ifdef CV32E40P_X_RESULT_BYPASS_EN
    assign bypass_s = empty_s & ~core_we_wb_i & accept_s & x_result_we_i & (x_result_rd_i != 5'd0);
`else
    assign bypass_s = 1'b0;
`endif

    // Results without a real destination are swallowed here.
    assign push_s = accept_s & x_result_we_i & (x_result_rd_i != 5'd0) & ~bypass_s;

    assign x_result_ready_o = ~full_s;
    assign buf_empty_o      = empty_s;
    assign buf_full_o       = full_s;
    assign x_wb_stall_req_o = rst_ni & (starve_r == STARVE_MAX);

    // FIFO storage, pointers, occupancy and starvation tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= 32'd0;
                rd_mem_r[i]   <= 5'd0;
                id_mem_r[i]   <= 4'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            starve_r <= 4'd0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= x_result_data_i;
                rd_mem_r[wr_ptr_r]   <= x_result_rd_i;
                id_mem_r[wr_ptr_r]   <= x_result_id_i;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s || empty_s) begin
                starve_r <= 4'd0;
            end else if (starve_r != STARVE_MAX) begin
                starve_r <= starve_r + 4'd1;
            end else begin
                starve_r <= starve_r;
            end
        end
    end

    // Port-B write and scoreboard clear come from the head entry, or straight from the channel on bypass.
    always_comb begin
        rf_we_o          = 1'b0;
        rf_waddr_o       = 5'd0;
        rf_wdata_o       = 32'd0;
        sb_clear_valid_o = 1'b0;
        sb_clear_rd_o    = 5'd0;
        sb_clear_id_o    = 4'd0;
        if (pop_s) begin
            rf_we_o          = 1'b1;
            rf_waddr_o       = rd_mem_r[rd_ptr_r];
            rf_wdata_o       = data_mem_r[rd_ptr_r];
            sb_clear_valid_o = 1'b1;
            sb_clear_rd_o    = rd_mem_r[rd_ptr_r];
            sb_clear_id_o    = id_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            rf_we_o          = 1'b1;
            rf_waddr_o       = x_result_rd_i;
            rf_wdata_o       = x_result_data_i;
            sb_clear_valid_o = 1'b1;
            sb_clear_rd_o    = x_result_rd_i;
            sb_clear_id_o    = x_result_id_i;
        end else begin
            rf_we_o          = 1'b0;
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_result_buf.sv
// Self-checking bench for cv32e40p_x_result_buf: queue-based reference model plus directed literal checks.
module tb_cv32e40p_x_result_buf;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  id = 4'd0;
    logic [31:0] data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        we = 1'b0;
    logic        core_we = 1'b0;

    logic        ready, rf_we, sb_v, stall, empty, full;
    logic [4:0]  waddr, sb_rd;
    logic [31:0] wdata;
    logic [3:0]  sb_id;

    cv32e40p_x_result_buf #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .x_result_valid_i(valid), .x_result_ready_o(ready),
        .x_result_id_i(id), .x_result_data_i(data), .x_result_rd_i(rd), .x_result_we_i(we),
        .core_we_wb_i(core_we),
        .rf_we_o(rf_we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
        .sb_clear_valid_o(sb_v), .sb_clear_rd_o(sb_rd), .sb_clear_id_o(sb_id),
        .x_wb_stall_req_o(stall), .buf_empty_o(empty), .buf_full_o(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          starve = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          check_en = 1'b0;
    logic [31:0] rf_shadow [32];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_bypass();
`ifdef CV32E40P_X_RESULT_BYPASS_EN
        return rst_n && q.size() == 0 && !core_we && valid && we && rd != 5'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: a queue of pending writes and a blocked-cycle count.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            starve = 0;
        end else begin
            automatic bit was_empty = (q.size() == 0);
            automatic bit do_pop = !was_empty && !core_we;
            automatic bit acc = valid && (q.size() != DEPTH);
            automatic bit byp = model_bypass();
            if (do_pop) void'(q.pop_front());
            if (acc && we && rd != 5'd0 && !byp) q.push_back('{id: id, rd: rd, data: data});
            if (do_pop || was_empty) starve = 0;
            else if (starve < STARVE_LIMIT) starve = starve + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            automatic bit e_empty = !rst_n || q.size() == 0;
            automatic bit e_full  = rst_n && q.size() == DEPTH;
            automatic bit e_pop   = !e_empty && !core_we;
            automatic bit e_byp   = model_bypass();
            automatic logic [4:0]  e_rd   = e_pop ? q[0].rd   : (e_byp ? rd   : 5'd0);
            automatic logic [31:0] e_data = e_pop ? q[0].data : (e_byp ? data : 32'd0);
            automatic logic [3:0]  e_id   = e_pop ? q[0].id   : (e_byp ? id   : 4'd0);
            cmp("m_ready", {31'd0, ready}, {31'd0, !e_full});
            cmp("m_empty", {31'd0, empty}, {31'd0, e_empty});
            cmp("m_full",  {31'd0, full},  {31'd0, e_full});
            cmp("m_stall", {31'd0, stall}, {31'd0, rst_n && starve == STARVE_LIMIT});
            cmp("m_rf_we", {31'd0, rf_we}, {31'd0, e_pop || e_byp});
            cmp("m_sb_v",  {31'd0, sb_v},  {31'd0, e_pop || e_byp});
            cmp("m_waddr", {27'd0, waddr}, {27'd0, e_rd});
            cmp("m_wdata", wdata, e_data);
            cmp("m_sb_rd", {27'd0, sb_rd}, {27'd0, e_rd});
            cmp("m_sb_id", {28'd0, sb_id}, {28'd0, e_id});
        end
        if (rf_we === 1'b1) rf_shadow[waddr] <= wdata;
    end

    task automatic drive(input logic v, input logic [3:0] i, input logic [4:0] r,
                         input logic [31:0] d, input logic w, input logic c);
        valid = v; id = i; rd = r; data = d; we = w; core_we = c;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf_shadow[k] = 32'd0;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        cyc(); cyc();
        check_en = 1'b1;
        @(negedge clk);
        cmp("rst_empty", {31'd0, empty}, 32'd1);
        cmp("rst_ready", {31'd0, ready}, 32'd1);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        cmp("post_rst_rf_we", {31'd0, rf_we}, 32'd0);
        cmp("post_rst_stall", {31'd0, stall}, 32'd0);
        cyc();

        // Single result, free port.
        drive(1'b1, 4'd3, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clk);
`ifdef CV32E40P_X_RESULT_BYPASS_EN
        cmp("t1_byp_we", {31'd0, rf_we}, 32'd1);
        cmp("t1_byp_addr", {27'd0, waddr}, 32'd5);
        cmp("t1_byp_data", wdata, 32'hDEADBEEF);
`else
        cmp("t1_n_we", {31'd0, rf_we}, 32'd0);
        cmp("t1_n_empty", {31'd0, empty}, 32'd1);
`endif
        cyc();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef CV32E40P_X_RESULT_BYPASS_EN
        cmp("t1_n1_we", {31'd0, rf_we}, 32'd0);
`else
        cmp("t1_n1_we", {31'd0, rf_we}, 32'd1);
        cmp("t1_n1_addr", {27'd0, waddr}, 32'd5);
        cmp("t1_n1_data", wdata, 32'hDEADBEEF);
        cmp("t1_n1_sbv", {31'd0, sb_v}, 32'd1);
        cmp("t1_n1_sbrd", {27'd0, sb_rd}, 32'd5);
        cmp("t1_n1_sbid", {28'd0, sb_id}, 32'd3);
`endif
        cyc();
        @(negedge clk);
        cmp("t1_empty_after", {31'd0, empty}, 32'd1);
        cyc();

        // Fill while core owns the port, then starve and drain.
        drive(1'b1, 4'd1, 5'd1, 32'h11111111, 1'b1, 1'b1); cyc();
        drive(1'b1, 4'd2, 5'd2, 32'h22222222, 1'b1, 1'b1); cyc();
        drive(1'b1, 4'd4, 5'd3, 32'h33333333, 1'b1, 1'b1);
        @(negedge clk);
        cmp("t2_full", {31'd0, full}, 32'd1);
        cmp("t2_ready", {31'd0, ready}, 32'd0);
        cmp("t2_stall_early", {31'd0, stall}, 32'd0);
        cyc(); cyc();
        @(negedge clk);
        cmp("t2_stall_pre", {31'd0, stall}, 32'd0);
        cyc();
        @(negedge clk);
        cmp("t2_stall", {31'd0, stall}, 32'd1);
        cyc();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        cmp("t2_drain1", {27'd0, waddr}, 32'd1);
        cyc();
        @(negedge clk);
        cmp("t2_drain2", {27'd0, waddr}, 32'd2);
        cmp("t2_drain2_data", wdata, 32'h22222222);
        cyc();
        @(negedge clk);
        cmp("t2_empty", {31'd0, empty}, 32'd1);
        cmp("t2_stall_clr", {31'd0, stall}, 32'd0);
        cyc();

        // Results without a write target are dropped.
        drive(1'b1, 4'd5, 5'd4, 32'h0BADF00D, 1'b0, 1'b0); cyc();
        drive(1'b1, 4'd6, 5'd0, 32'h0BADF00D, 1'b1, 1'b0);
        @(negedge clk);
        cmp("t3_empty_a", {31'd0, empty}, 32'd1);
        cmp("t3_no_we", {31'd0, rf_we}, 32'd0);
        cyc();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        cmp("t3_empty_b", {31'd0, empty}, 32'd1);
        cmp("t3_no_sbv", {31'd0, sb_v}, 32'd0);
        cyc();

        // Simultaneous push and pop.
        drive(1'b1, 4'd7, 5'd4, 32'h44444444, 1'b1, 1'b1); cyc();
        drive(1'b1, 4'd8, 5'd7, 32'h77777777, 1'b1, 1'b0);
        @(negedge clk);
        cmp("t4_pop_addr", {27'd0, waddr}, 32'd4);
        cyc();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        cmp("t4_count1", {30'd0, full, empty}, 32'd0);
        cmp("t4_next_addr", {27'd0, waddr}, 32'd7);
        cyc();

        // Fill, then reset discards everything.
        drive(1'b1, 4'd1, 5'd10, 32'hAAAA000A, 1'b1, 1'b1); cyc();
        drive(1'b1, 4'd2, 5'd11, 32'hAAAA000B, 1'b1, 1'b1); cyc();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        cmp("t5_rst_we", {31'd0, rf_we}, 32'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        cmp("t5_empty", {31'd0, empty}, 32'd1);
        cmp("t5_ready", {31'd0, ready}, 32'd1);
        cmp("t5_we", {31'd0, rf_we}, 32'd0);
        cyc(); cyc();

        // Same destination twice: last result wins.
        drive(1'b1, 4'd1, 5'd9, 32'hA0A0A0A0, 1'b1, 1'b0); cyc();
        drive(1'b1, 4'd2, 5'd9, 32'hB0B0B0B0, 1'b1, 1'b0); cyc();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        cyc(); cyc(); cyc();
        cmp("t6_final_rf9", rf_shadow[9], 32'hB0B0B0B0);
        cmp("t6_rf10_untouched", rf_shadow[10], 32'd0);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
